// File: rtl/logic_pipe_if.sv
// Handshake bundle for logic_pipe: operand/op input channel and result output channel.
// The master drives operands and out_ready; the slave (the pipe) drives the rest.
interface logic_pipe_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [2:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_z;
    logic               out_zero;
    logic [COUNT_W-1:0] out_count;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_z, out_zero, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_z, out_zero, out_count
    );
endinterface

// File: rtl/logic_pipe.sv
// Pipelined two-input bitwise gate unit with valid/ready on both sides.
// STAGES elastic register stages; bubbles collapse and ready ripples back combinationally.
module logic_pipe #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    logic_pipe_if.slave  bus
);
    logic [WIDTH-1:0]   w_f;
    logic               w_f_zero;
    logic [STAGES-1:0]  w_load;
    logic               w_out_xfer;

    logic               r_valid [STAGES];
    logic [WIDTH-1:0]   r_z     [STAGES];
    logic               r_zero  [STAGES];
    logic [COUNT_W-1:0] r_count;

    always_comb begin
        w_f = '0;
        case (bus.in_op)
            3'd0:    w_f = bus.in_a & bus.in_b;
            3'd1:    w_f = bus.in_a & ~bus.in_b;
            3'd2:    w_f = bus.in_a | bus.in_b;
            3'd3:    w_f = bus.in_a ^ bus.in_b;
            3'd4:    w_f = ~(bus.in_a & bus.in_b);
            3'd5:    w_f = ~(bus.in_a | bus.in_b);
            3'd6:    w_f = ~(bus.in_a ^ bus.in_b);
            default: w_f = ~bus.in_b;
        endcase
    end

    assign w_f_zero   = (w_f == '0);
    assign w_out_xfer = r_valid[STAGES-1] & bus.out_ready;

    // A stage may load when it is empty or its successor is taking its contents.
    always_comb begin
        w_load = '0;
        w_load[STAGES-1] = ~r_valid[STAGES-1] | bus.out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_load[i] = ~r_valid[i] | w_load[i+1];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid[gi] <= 1'b0;
                    r_z[gi]     <= '0;
                    r_zero[gi]  <= 1'b0;
                end else if (w_load[gi]) begin
                    r_valid[gi] <= bus.in_valid;
                    r_z[gi]     <= w_f;
                    r_zero[gi]  <= w_f_zero;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid[gi] <= 1'b0;
                    r_z[gi]     <= '0;
                    r_zero[gi]  <= 1'b0;
                end else if (w_load[gi]) begin
                    r_valid[gi] <= r_valid[gi-1];
                    r_z[gi]     <= r_z[gi-1];
                    r_zero[gi]  <= r_zero[gi-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_out_xfer) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.in_ready  = ~reset & w_load[0];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.out_z     = r_z[STAGES-1];
    assign bus.out_zero  = r_zero[STAGES-1];
    assign bus.out_count = r_count;
endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: a truth-table model feeds an expected queue on each
// input transfer; an independent monitor pops and compares on each output transfer.
module tb_logic_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset4 = 1'b1;

    always #5 clk = ~clk;

    logic_pipe_if #(.WIDTH(8), .COUNT_W(16)) bus ();
    logic_pipe_if #(.WIDTH(8), .COUNT_W(4))  bus4 ();

    logic_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic_pipe #(.WIDTH(8), .STAGES(3), .COUNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset4),
        .bus   (bus4)
    );

    int errors = 0;
    int checks = 0;
    int n_in   = 0;
    int n_out  = 0;
    int n4     = 0;
    bit done4  = 1'b0;
    bit held   = 1'b0;
    logic [8:0] prev_out;
    logic [8:0] exp_q [$];
    logic [7:0] seen  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Each op is a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        logic [3:0] tt;
        logic [7:0] z;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b0100;
            3'd2:    tt = 4'b1110;
            3'd3:    tt = 4'b0110;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b0001;
            3'd6:    tt = 4'b1001;
            default: tt = 4'b0101;
        endcase
        for (int k = 0; k < 8; k++) z[k] = tt[{a[k], b[k]}];
        return z;
    endfunction

    always @(negedge clk) begin
        logic [7:0] z;
        if (reset) begin
            exp_q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            z = ref_fn(bus.in_a, bus.in_b, bus.in_op);
            exp_q.push_back({(z == 8'h00), z});
            n_in++;
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            n_out = 0;
            held  = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", {bus.out_zero, bus.out_z}, prev_out);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out actual=%0h required=none", bus.out_z);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_z", bus.out_z, e[7:0]);
                    chk("out_zero", bus.out_zero, e[8]);
                    chk("out_count", bus.out_count, n_out[15:0]);
                    $display("OUT #%0d z=%02h zero=%0d count=%0d", n_out, bus.out_z,
                             bus.out_zero, bus.out_count);
                    n_out++;
                    seen.push_back(bus.out_z);
                end
            end
            held     = bus.out_valid && !bus.out_ready;
            prev_out = {bus.out_zero, bus.out_z};
        end
    end

    // Narrow-counter instance streams continuously to exercise wrap 15 -> 0 -> 1.
    initial begin
        bus4.in_valid  = 1'b1;
        bus4.in_a      = 8'h12;
        bus4.in_b      = 8'h21;
        bus4.in_op     = 3'd2;
        bus4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset4 = 1'b0;
    end

    always @(negedge clk) begin
        if (!reset4 && !done4 && bus4.out_valid && bus4.out_ready) begin
            chk("cnt4", bus4.out_count, n4[3:0]);
            chk("z4", bus4.out_z, 8'h33);
            $display("OUT4 #%0d count=%0d", n4, bus4.out_count);
            n4++;
            if (n4 == 20) done4 = 1'b1;
        end
    end

    initial begin
        int base;
        int cyc;
        logic [7:0] exp2 [8];
        exp2 = '{8'h00, 8'hC5, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC5};
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.in_op     = 3'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_z", bus.out_z, 0);
        chk("rst_zero", bus.out_zero, 0);
        chk("rst_count", bus.out_count, 0);
        chk("rst_in_ready", bus.in_ready, 0);

        // ANDN of equal all-ones operands: zero result after the pipeline latency.
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.in_op = 3'd1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_lat_early", bus.out_valid, 0);
        @(negedge clk);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_z", bus.out_z, 8'h00);
        chk("t1_zero", bus.out_zero, 1);
        @(negedge clk);
        chk("t1_count", bus.out_count, 1);

        @(posedge clk); #1;
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 8'hC5; bus.in_b = 8'h3A; bus.in_op = 3'(i);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        for (cyc = 0; cyc < 50 && seen.size() < 8; cyc++) @(posedge clk);
        #1;
        chk("t2_n", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("t2_z", seen[i], exp2[i]);

        // Stall the output: only STAGES operands may be accepted.
        bus.out_ready = 1'b0;
        base = n_in;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
            bus.in_op = 3'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_accepted", n_in - base, 2);
        chk("t3_in_ready_full", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_in_ready_rise", bus.in_ready, 1);
        for (cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) @(posedge clk);
        @(negedge clk);
        chk("t3_drained", exp_q.size(), 0);

        @(posedge clk); #1;
        base = n_in;
        for (cyc = 0; cyc < 30000 && (n_in - base) < 1000; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_a  = 8'($urandom);
            bus.in_b  = 8'($urandom);
            bus.in_op = 3'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) @(posedge clk);
        @(negedge clk);
        chk("t4_inputs", n_in - base, 1000);
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_count", bus.out_count, n_out[15:0]);

        // Reset with two results in flight discards them.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 8'h5A; bus.in_b = 8'h0F; bus.in_op = 3'd2;
        @(posedge clk); #1;
        bus.in_a = 8'h77;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_count", bus.out_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        seen.delete();
        bus.in_valid = 1'b1; bus.in_a = 8'h01; bus.in_b = 8'h00; bus.in_op = 3'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (cyc = 0; cyc < 20 && seen.size() < 1; cyc++) @(posedge clk);
        @(negedge clk);
        chk("t6_seen", seen.size(), 1);
        if (seen.size() > 0) chk("t6_z", seen[0], 8'h01);

        for (cyc = 0; cyc < 200 && !done4; cyc++) @(posedge clk);
        chk("t5_done", done4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
